// File: rtl/flip_filter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : flip_filter_pkg                                              |
// | Description : Shared types and default sizes for the flip filter blocks.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package flip_filter_pkg;

    localparam int DEFAULT_NUM_REQ = 256;
    localparam int IDX_W           = $clog2(DEFAULT_NUM_REQ);
    localparam int DEFAULT_CNT_W   = $clog2(DEFAULT_NUM_REQ + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fs_state_e;

endpackage

`default_nettype wire

// File: rtl/customized_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : customized_arbiter                                           |
// | Description : Fixed-priority one-hot arbiter with binary grant index.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module customized_arbiter #(
    parameter int NUM_REQ      = 256,
    parameter int PIPES        = 0,
    parameter bit LSB_PRIORITY = 1'b1,
    parameter int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;

    assign w_req = req_valid_i ? req_i : '0;

    // The last set bit visited wins, so scan direction sets the priority.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        if (LSB_PRIORITY) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_req[i]) begin
                    w_grant    = '0;
                    w_grant[i] = 1'b1;
                    w_idx      = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_req[i]) begin
                    w_grant    = '0;
                    w_grant[i] = 1'b1;
                    w_idx      = IDX_W'(i);
                end
            end
        end
    end

    if (PIPES == 0) begin : g_comb
        logic w_unused;
        assign w_unused = &{1'b0, clk_i, rst_ni};
        assign grant_o  = w_grant;
        assign idx_o    = w_idx;
    end else begin : g_pipe
        logic [NUM_REQ-1:0] r_grant;
        logic [IDX_W-1:0]   r_idx;
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_grant <= '0;
                r_idx   <= '0;
            end else begin
                r_grant <= w_grant;
                r_idx   <= w_idx;
            end
        end
        assign grant_o = r_grant;
        assign idx_o   = r_idx;
    end

endmodule

`default_nettype wire

// File: rtl/flip_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : flip_sequencer                                               |
// | Description : Drains a flip-request vector one priority index at a time.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module flip_sequencer
    import flip_filter_pkg::*;
#(
    parameter int NUM_REQ      = 256,
    parameter bit LSB_PRIORITY = 1'b1,
    parameter int CNT_W        = $clog2(NUM_REQ + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       vec_valid_i,
    output logic                       vec_ready_o,
    input  logic [NUM_REQ-1:0]         vec_i,
    input  logic [CNT_W-1:0]           budget_i,
    output logic                       idx_valid_o,
    input  logic                       idx_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       done_o,
    output logic [CNT_W-1:0]           flip_cnt_o
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    fs_state_e          r_state;
    fs_state_e          w_state_nxt;
    logic [NUM_REQ-1:0] r_mask;
    logic [CNT_W-1:0]   r_budget;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_flip_cnt;
    logic [NUM_REQ-1:0] w_grant;
    logic [c_idx_w-1:0] w_idx;
    logic               w_idx_valid;
    logic               w_load;
    logic               w_take;

    customized_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .PIPES        (0),
        .LSB_PRIORITY (LSB_PRIORITY),
        .IDX_W        (c_idx_w)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (~rst_i),
        .req_valid_i (1'b1),
        .req_i       (r_mask),
        .grant_o     (w_grant),
        .idx_o       (w_idx)
    );

    assign w_idx_valid = (r_state == SCAN) && (r_mask != '0) && (r_budget != '0);
    assign w_load      = (r_state == IDLE) && vec_valid_i && !flush_i;
    // A flush in the same cycle drops the handshake entirely.
    assign w_take      = w_idx_valid && idx_ready_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (vec_valid_i) w_state_nxt = SCAN;
            SCAN:    if (!w_idx_valid) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mask     <= '0;
            r_budget   <= '0;
            r_cnt      <= '0;
            r_flip_cnt <= '0;
        end else if (flush_i) begin
            r_mask <= '0;
        end else begin
            if (w_load) begin
                r_mask   <= vec_i;
                r_budget <= budget_i;
                r_cnt    <= '0;
            end else if (w_take) begin
                r_mask   <= r_mask & ~w_grant;
                r_budget <= r_budget - CNT_W'(1);
                r_cnt    <= r_cnt + CNT_W'(1);
            end
            // Captured on the SCAN->DONE transition so it survives the next load.
            if ((r_state == SCAN) && !w_idx_valid) begin
                r_flip_cnt <= r_cnt;
            end
        end
    end

    always_comb begin
        vec_ready_o = (r_state == IDLE) && !rst_i;
        idx_valid_o = w_idx_valid;
        done_o      = (r_state == DONE);
        idx_o       = w_idx;
        flip_cnt_o  = r_flip_cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_flip_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_flip_sequencer                                            |
// | Description : Self-checking bench for flip_sequencer (8-bit LSB, 256 MSB). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_flip_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         vec_valid;
    logic         idx_ready;
    logic         sel;
    logic [255:0] vec;
    logic [8:0]   budget;

    logic       a_vec_ready, a_idx_valid, a_done;
    logic [2:0] a_idx;
    logic [3:0] a_flip;
    logic       b_vec_ready, b_idx_valid, b_done;
    logic [7:0] b_idx;
    logic [8:0] b_flip;

    logic [31:0] o_vec_ready, o_idx_valid, o_done, o_idx, o_flip;

    int n_tests = 0;
    int n_fail  = 0;
    int last_flip [2];

    always #5 clk = ~clk;

    flip_sequencer #(.NUM_REQ(8), .LSB_PRIORITY(1'b1)) u_dut8 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .vec_valid_i (vec_valid & ~sel),
        .vec_ready_o (a_vec_ready),
        .vec_i       (vec[7:0]),
        .budget_i    (budget[3:0]),
        .idx_valid_o (a_idx_valid),
        .idx_ready_i (idx_ready),
        .idx_o       (a_idx),
        .done_o      (a_done),
        .flip_cnt_o  (a_flip)
    );

    flip_sequencer #(.NUM_REQ(256), .LSB_PRIORITY(1'b0)) u_dut256 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .vec_valid_i (vec_valid & sel),
        .vec_ready_o (b_vec_ready),
        .vec_i       (vec),
        .budget_i    (budget),
        .idx_valid_o (b_idx_valid),
        .idx_ready_i (idx_ready),
        .idx_o       (b_idx),
        .done_o      (b_done),
        .flip_cnt_o  (b_flip)
    );

    always_comb begin
        o_vec_ready = sel ? 32'(b_vec_ready) : 32'(a_vec_ready);
        o_idx_valid = sel ? 32'(b_idx_valid) : 32'(a_idx_valid);
        o_done      = sel ? 32'(b_done)      : 32'(a_done);
        o_idx       = sel ? 32'(b_idx)       : 32'(a_idx);
        o_flip      = sel ? 32'(b_flip)      : 32'(a_flip);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: indices in priority order, truncated to the budget.
    task automatic run_vec(input bit s, input logic [255:0] v, input int bud, input int rmode);
        int  n;
        int  exp_q[$];
        int  got;
        int  e;
        int  w;
        int  k;
        bit  rdy;
        bit  prev_hold;
        int  prev_idx;
        n = s ? 256 : 8;
        if (s) begin
            for (int i = n - 1; i >= 0; i--) if (v[i]) exp_q.push_back(i);
        end else begin
            for (int i = 0; i < n; i++) if (v[i]) exp_q.push_back(i);
        end
        while (exp_q.size() > bud) void'(exp_q.pop_back());

        sel = s;
        w = 0;
        while (o_vec_ready != 1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("vec_ready_pre", o_vec_ready, 1);
        vec       = v;
        budget    = 9'(bud);
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;

        got       = 0;
        e         = -1;
        prev_hold = 1'b0;
        prev_idx  = 0;
        for (k = 1; k < 4000; k++) begin
            if (got < exp_q.size()) begin
                check("idx_valid", o_idx_valid, 1);
                check("idx", o_idx, exp_q[got]);
                check("done_early", o_done, 0);
                if (prev_hold) check("idx_hold", o_idx, prev_idx);
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    default: rdy = (k % 2 == 0);
                endcase
                idx_ready = rdy;
                prev_hold = !rdy;
                prev_idx  = int'(o_idx);
                if (rdy) got++;
            end else begin
                if (e < 0) e = k;
                idx_ready = 1'($urandom_range(0, 1));
                if (k == e) begin
                    check("valid_after_last", o_idx_valid, 0);
                    check("done_early", o_done, 0);
                end else if (k == e + 1) begin
                    check("done", o_done, 1);
                    check("flip_cnt", o_flip, exp_q.size());
                    last_flip[s] = exp_q.size();
                end else begin
                    check("vec_ready_post", o_vec_ready, 1);
                    check("done_pulse_len", o_done, 0);
                    check("flip_cnt_hold", o_flip, exp_q.size());
                    break;
                end
            end
            @(negedge clk);
        end
        if (k >= 4000) check("timeout", 0, 1);
        idx_ready = 1'b0;
    endtask

    initial begin
        logic [255:0] v;
        int           bud;
        rst = 1'b1; flush = 1'b0; vec_valid = 1'b0; idx_ready = 1'b0;
        sel = 1'b0; vec = '0; budget = '0;
        last_flip[0] = 0;
        last_flip[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_vec_ready8", 32'(a_vec_ready), 0);
        check("rst_vec_ready256", 32'(b_vec_ready), 0);
        check("rst_idx_valid8", 32'(a_idx_valid), 0);
        check("rst_done256", 32'(b_done), 0);
        check("rst_flip8", 32'(a_flip), 0);
        check("rst_idx256", 32'(b_idx), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready8", 32'(a_vec_ready), 1);
        check("post_rst_ready256", 32'(b_vec_ready), 1);

        run_vec(1'b0, 256'hA6, 8, 0);
        run_vec(1'b0, 256'hA6, 2, 0);
        run_vec(1'b1, 256'hA6, 8, 2);
        run_vec(1'b0, 256'h00, 5, 0);
        run_vec(1'b0, 256'hFF, 0, 0);
        run_vec(1'b1, {256{1'b1}}, 300, 0);

        // Flush during the second handshake of 0xFF.
        sel = 1'b0; vec = 256'hFF; budget = 9'd8;
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        idx_ready = 1'b1;
        check("flush_idx0", o_idx, 0);
        @(negedge clk);
        check("flush_idx1", o_idx, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        idx_ready = 1'b0;
        check("flush_valid", o_idx_valid, 0);
        check("flush_done", o_done, 0);
        check("flush_ready", o_vec_ready, 1);
        check("flush_flip_hold", o_flip, last_flip[0]);
        @(negedge clk);
        check("flush_done2", o_done, 0);
        run_vec(1'b0, 256'h5A, 15, 1);

        // Reset pulsed mid-scan of a full 256-bit vector.
        sel = 1'b1; vec = {256{1'b1}}; budget = 9'd256;
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        idx_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", o_idx_valid, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_flip", o_flip, 0);
        check("mid_rst_idx", o_idx, 0);
        check("mid_rst_ready", o_vec_ready, 0);
        rst = 1'b0;
        idx_ready = 1'b0;
        last_flip[0] = 0;
        last_flip[1] = 0;
        @(negedge clk);
        check("mid_rst_ready_after", o_vec_ready, 1);

        for (int i = 0; i < 1000; i++) begin
            if (i % 2 == 0) begin
                v   = 256'($urandom_range(0, 255));
                bud = $urandom_range(0, 10);
                run_vec(1'b0, v, bud, 1);
            end else begin
                for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom & $urandom & $urandom;
                if ($urandom_range(0, 7) == 0) begin
                    for (int j = 0; j < 8; j++) v[j*32 +: 32] = v[j*32 +: 32] & $urandom;
                    bud = $urandom_range(257, 300);
                end else begin
                    bud = $urandom_range(0, 40);
                end
                run_vec(1'b1, v, bud, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
